// File: rtl/ps_serial_if.sv
// Handshake and state bus for ps_serial; abort_i exists only when PS_SERIAL_ABORT_EN is defined.
interface ps_serial_if;
  logic              start_i;
  logic [0:4][63:0]  Ps_in_i;
  logic [0:4][63:0]  Ps_out_o;
  logic              busy_o;
  logic              done_o;
`ifdef PS_SERIAL_ABORT_EN
  logic              abort_i;

  modport master (output start_i, Ps_in_i, abort_i, input Ps_out_o, busy_o, done_o);
  modport slave  (input start_i, Ps_in_i, abort_i, output Ps_out_o, busy_o, done_o);
`else
  modport master (output start_i, Ps_in_i, input Ps_out_o, busy_o, done_o);
  modport slave  (input start_i, Ps_in_i, output Ps_out_o, busy_o, done_o);
`endif
endinterface

// File: rtl/ps_serial.sv
// Chunked Ascon S-box layer: COLS_PER_CYCLE columns of the 5x64 state substituted per cycle.
// Optional abort input enabled by defining PS_SERIAL_ABORT_EN.
//
// state  | meaning
// IDLE   | waiting for start_i, register holds last result
// RUN    | substituting chunk cnt_q, start_i ignored
// DONE   | result complete, done_o high for this one cycle
module ps_serial #(
  parameter int COLS_PER_CYCLE = 8
) (
  input  logic   clock_i,
  input  logic   reset_i,
  ps_serial_if.slave ps
);

  localparam int C   = COLS_PER_CYCLE;
  localparam int NCH = 64 / C;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef logic [0:4][63:0] type_state;

  logic [1:0]    state_q;
  logic [CW-1:0] cnt_q;
  type_state     work_q;
  type_state     work_nx;

  function automatic logic [4:0] sbox(input logic [4:0] x);
    logic [4:0] y;
    case (x)
      5'd0:  y = 5'h04;  5'd1:  y = 5'h0B;  5'd2:  y = 5'h1F;  5'd3:  y = 5'h14;
      5'd4:  y = 5'h1A;  5'd5:  y = 5'h15;  5'd6:  y = 5'h09;  5'd7:  y = 5'h02;
      5'd8:  y = 5'h1B;  5'd9:  y = 5'h05;  5'd10: y = 5'h08;  5'd11: y = 5'h12;
      5'd12: y = 5'h1D;  5'd13: y = 5'h03;  5'd14: y = 5'h06;  5'd15: y = 5'h1C;
      5'd16: y = 5'h1E;  5'd17: y = 5'h13;  5'd18: y = 5'h07;  5'd19: y = 5'h0E;
      5'd20: y = 5'h00;  5'd21: y = 5'h0D;  5'd22: y = 5'h11;  5'd23: y = 5'h18;
      5'd24: y = 5'h10;  5'd25: y = 5'h0C;  5'd26: y = 5'h01;  5'd27: y = 5'h19;
      5'd28: y = 5'h16;  5'd29: y = 5'h0A;  5'd30: y = 5'h0F;  default: y = 5'h17;
    endcase
    return y;
  endfunction

  // Only the columns of the current chunk are rewritten; everything else passes through.
  always_comb begin
    logic [5:0] idx;
    logic [4:0] col;
    logic [4:0] sub;
    work_nx = work_q;
    idx     = '0;
    col     = '0;
    sub     = '0;
    for (int j = 0; j < C; j++) begin
      idx = 6'(int'(cnt_q) * C + j);
      col = {work_q[0][idx], work_q[1][idx], work_q[2][idx], work_q[3][idx], work_q[4][idx]};
      sub = sbox(col);
      work_nx[0][idx] = sub[4];
      work_nx[1][idx] = sub[3];
      work_nx[2][idx] = sub[2];
      work_nx[3][idx] = sub[1];
      work_nx[4][idx] = sub[0];
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (ps.start_i) begin
            work_q  <= ps.Ps_in_i;
            cnt_q   <= '0;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
`ifdef PS_SERIAL_ABORT_EN
          if (ps.abort_i) state_q <= S_IDLE;
          else
`endif
          begin
            work_q <= work_nx;
            // Counter parks on the last chunk; it is cleared on the next accept.
            if (cnt_q == LAST) state_q <= S_DONE;
            else               cnt_q   <= cnt_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ps.busy_o   = (state_q == S_RUN);
  assign ps.done_o   = (state_q == S_DONE);
  assign ps.Ps_out_o = work_q;

endmodule

// File: tb/tb_ps_serial.sv
// Randomized bench for ps_serial (C = 1, 8, 64) against a column-wise S-box reference model.
module tb_ps_serial;
  typedef logic [0:4][63:0] st_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic start;
  st_t  ps_in;
`ifdef PS_SERIAL_ABORT_EN
  logic abort;
`endif

  ps_serial_if ifc1 ();
  ps_serial_if ifc8 ();
  ps_serial_if ifc64 ();

  assign ifc1.start_i  = start;
  assign ifc8.start_i  = start;
  assign ifc64.start_i = start;
  assign ifc1.Ps_in_i  = ps_in;
  assign ifc8.Ps_in_i  = ps_in;
  assign ifc64.Ps_in_i = ps_in;
`ifdef PS_SERIAL_ABORT_EN
  assign ifc1.abort_i  = abort;
  assign ifc8.abort_i  = abort;
  assign ifc64.abort_i = abort;
`endif

  ps_serial #(.COLS_PER_CYCLE(1))  u_c1  (.clock_i(clk), .reset_i(reset), .ps(ifc1));
  ps_serial #(.COLS_PER_CYCLE(8))  u_c8  (.clock_i(clk), .reset_i(reset), .ps(ifc8));
  ps_serial #(.COLS_PER_CYCLE(64)) u_c64 (.clock_i(clk), .reset_i(reset), .ps(ifc64));

  int n_chk = 0;
  int n_err = 0;

  logic [4:0] sbox_tbl [32] = '{
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Substitute the lowest ncols columns, leave the rest untouched.
  function automatic st_t ref_sub(input st_t s, input int ncols);
    st_t r;
    logic [4:0] v;
    r = s;
    for (int j = 0; j < ncols; j++) begin
      v = {s[0][j], s[1][j], s[2][j], s[3][j], s[4][j]};
      v = sbox_tbl[v];
      r[0][j] = v[4]; r[1][j] = v[3]; r[2][j] = v[2]; r[3][j] = v[1]; r[4][j] = v[0];
    end
    return r;
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done8(input int budget, output int cycles);
    cycles = 0;
    while (!ifc8.done_o && cycles < budget) begin
      step();
      cycles++;
    end
  endtask

  // Run one operation on all three widths in parallel; checks latency, pulse count, result.
  task automatic launch_all(input st_t s, input string name, output st_t res8);
    int   lat [3];
    int   nd  [3];
    st_t  res [3];
    int   exp_lat [3];
    logic dn [3];
    st_t  ob [3];
    exp_lat = '{65, 9, 2};
    for (int i = 0; i < 3; i++) begin lat[i] = 0; nd[i] = 0; res[i] = '0; end
    start = 1'b1;
    ps_in = s;
    for (int c = 1; c <= 70; c++) begin
      step();
      if (c == 1) start = 1'b0;
      dn[0] = ifc1.done_o;  ob[0] = ifc1.Ps_out_o;
      dn[1] = ifc8.done_o;  ob[1] = ifc8.Ps_out_o;
      dn[2] = ifc64.done_o; ob[2] = ifc64.Ps_out_o;
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin
          nd[i]++;
          if (lat[i] == 0) begin lat[i] = c; res[i] = ob[i]; end
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_lat_%0d", name, i), 320'(lat[i]), 320'(exp_lat[i]));
      chk($sformatf("%s_ndone_%0d", name, i), 320'(nd[i]), 320'd1);
      chk($sformatf("%s_res_%0d", name, i), res[i], ref_sub(s, 64));
    end
    chk({name, "_hold_c1"}, ifc1.Ps_out_o, ref_sub(s, 64));
    res8 = res[1];
  endtask

  initial begin
    st_t a, b, e, r8;
    int  n, nd, lat;
    reset = 1'b1;
    start = 1'b0;
    ps_in = '0;
`ifdef PS_SERIAL_ABORT_EN
    abort = 1'b0;
`endif
    ps_in = rand_state();
    start = 1'b1;
    step();
    step();
    chk("rst_busy", 320'({ifc1.busy_o, ifc8.busy_o, ifc64.busy_o}), 320'd0);
    chk("rst_done", 320'({ifc1.done_o, ifc8.done_o, ifc64.done_o}), 320'd0);
    chk("rst_out8", ifc8.Ps_out_o, '0);
    chk("rst_out64", ifc64.Ps_out_o, '0);
    start = 1'b0;
    reset = 1'b0;
    step();
    chk("idle_busy", 320'(ifc8.busy_o), 320'd0);

    launch_all('0, "zero", r8);
    e = '0; e[2] = '1;
    chk("zero_c8_const", r8, e);

    launch_all('1, "ones", r8);
    e = '1; e[1] = '0;
    chk("ones_c8_const", r8, e);
    chk("ones_c1_const", ifc1.Ps_out_o, e);
    chk("ones_c64_const", ifc64.Ps_out_o, e);

    launch_all(rand_state(), "rnd", r8);

    // Extra start pulses mid-run and on the last-chunk cycle must be ignored.
    a = rand_state();
    start = 1'b1; ps_in = a;
    step();
    start = 1'b0;
    chk("run_busy", 320'(ifc8.busy_o), 320'd1);
    lat = 0; nd = 0; r8 = '0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3 || c == 8) begin start = 1'b1; ps_in = rand_state(); end
      else start = 1'b0;
      step();
      if (ifc8.done_o) begin
        nd++;
        if (lat == 0) begin lat = c + 1; r8 = ifc8.Ps_out_o; end
      end
    end
    chk("ign_lat", 320'(lat), 320'd9);
    chk("ign_ndone", 320'(nd), 320'd1);
    chk("ign_res", r8, ref_sub(a, 64));
    chk("ign_hold", ifc8.Ps_out_o, ref_sub(a, 64));

    // Reset during RUN cycle 4.
    start = 1'b1; ps_in = rand_state();
    step();
    start = 1'b0;
    repeat (4) step();
    chk("pre_rst_busy", 320'(ifc8.busy_o), 320'd1);
    reset = 1'b1;
    step();
    chk("midrst_busy", 320'(ifc8.busy_o), 320'd0);
    chk("midrst_done", 320'(ifc8.done_o), 320'd0);
    chk("midrst_out", ifc8.Ps_out_o, '0);
    reset = 1'b0;
    nd = 0;
    repeat (12) begin step(); nd += int'(ifc8.done_o); end
    chk("midrst_nodone", 320'(nd), 320'd0);

    a = rand_state();
    start = 1'b1; ps_in = a;
    step();
    start = 1'b0;
    wait_done8(20, n);
    chk("after_rst_lat", 320'(n + 1), 320'd9);
    chk("after_rst_res", ifc8.Ps_out_o, ref_sub(a, 64));

    // start held high through DONE: back-to-back operations.
    step();
    a = rand_state();
    b = rand_state();
    start = 1'b1; ps_in = a;
    step();
    wait_done8(20, n);
    chk("b2b_lat1", 320'(n + 1), 320'd9);
    chk("b2b_res1", ifc8.Ps_out_o, ref_sub(a, 64));
    ps_in = b;
    step();
    chk("b2b_reaccept", 320'(ifc8.busy_o), 320'd1);
    wait_done8(20, n);
    chk("b2b_gap", 320'(n + 1), 320'd9);
    chk("b2b_res2", ifc8.Ps_out_o, ref_sub(b, 64));
    start = 1'b0;
    step();
    chk("b2b_idle", 320'({ifc8.busy_o, ifc8.done_o}), 320'd0);
    repeat (3) step();
    chk("b2b_hold", ifc8.Ps_out_o, ref_sub(b, 64));

`ifdef PS_SERIAL_ABORT_EN
    // Abort in RUN cycle 3: chunks 0-2 substituted, the rest untouched.
    a = rand_state();
    start = 1'b1; ps_in = a;
    step();
    start = 1'b0;
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_busy", 320'(ifc8.busy_o), 320'd0);
    chk("abort_out", ifc8.Ps_out_o, ref_sub(a, 24));
    nd = 0;
    repeat (12) begin step(); nd += int'(ifc8.done_o); end
    chk("abort_nodone", 320'(nd), 320'd0);
    chk("abort_hold", ifc8.Ps_out_o, ref_sub(a, 24));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ps_serial.md
PS_SERIAL -- requirements
Module: ps_serial

Interface
REQ-001 SHALL have parameter COLS_PER_CYCLE, default 8, giving the number of S-box columns processed per cycle; legal values are 1, 2, 4, 8, 16, 32 and 64.
REQ-002 SHALL have port clock_i, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port reset_i, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port start_i, input, 1 bit: request to substitute the state presented on Ps_in_i.
REQ-005 SHALL have port Ps_in_i, input, type_state (5 x 64 from ascon_pack): the state after constant addition.
REQ-006 SHALL have port Ps_out_o, output, type_state: the working register, holding the substituted state once complete.
REQ-007 SHALL have port busy_o, output, 1 bit: high while in RUN.
REQ-008 SHALL have port done_o, output, 1 bit: one-cycle pulse when Ps_out_o holds the complete result.

Function
REQ-009 SHALL implement three states, IDLE, RUN and DONE, with IDLE after reset.
REQ-010 SHALL accept start_i only in IDLE or DONE; on acceptance it loads Ps_in_i into the working register, clears the chunk counter and enters RUN.
REQ-011 SHALL process, in each RUN cycle, chunk k = bits [k*C+C-1 : k*C] of all five words, where C = COLS_PER_CYCLE and k counts up from 0.
REQ-012 SHALL read each column j as the 5-bit value {x0[j], x1[j], x2[j], x3[j], x4[j]} with x0 as MSB, and write back S(value) in the same bit order.
REQ-013 SHALL use the Ascon S-box S = 04 0B 1F 14 1A 15 09 02 1B 05 08 12 1D 03 06 1C 1E 13 07 0E 00 0D 11 18 10 0C 01 19 16 0A 0F 17 (hex, index 0..31).
REQ-014 SHALL keep the chunk counter at log2(64/C) bits (minimum 1); after the last chunk (k = 64/C-1) it goes to DONE instead of wrapping, and columns outside the current chunk stay unchanged.
REQ-015 SHALL have a latency from the start-accept edge to the rising of done_o of exactly 64/C+1 cycles (8 RUN cycles plus DONE for C=8).
REQ-016 SHALL assert done_o only in DONE, for exactly one cycle, and return to IDLE after DONE unless start_i is accepted in that cycle.
REQ-017 SHALL ignore start_i in RUN, including in the cycle of the last chunk, with no effect on the register or the counter.
REQ-018 SHALL hold Ps_out_o stable in IDLE and DONE; during RUN it shows partially substituted data and is not valid.

Reset
REQ-019 SHALL, on reset_i high at a clock edge, including mid-RUN, force state to IDLE, the counter to 0 and the working register to all-zero.
REQ-020 SHALL drive busy_o = 0, done_o = 0 and Ps_out_o = 0 from the first edge with reset_i high until the first edge after reset_i is released.
REQ-021 SHALL give reset priority over start_i and over abort_i when both are high.

Configuration
REQ-022 SHALL, when macro PS_SERIAL_ABORT_EN is defined, add input abort_i (1 bit); abort_i high in RUN returns the block to IDLE at the next edge, with no done_o pulse and the working register frozen.
REQ-023 SHALL, when PS_SERIAL_ABORT_EN is undefined, have no abort_i port and otherwise behave identically; abort_i has no effect outside RUN.

Verification
REQ-024 SHALL verify, with C=8, start_i and an all-zero Ps_in_i, that done_o pulses 9 cycles later with x2 = FFFFFFFFFFFFFFFF and x0, x1, x3, x4 = 0.
REQ-025 SHALL verify, with all-ones input, that the result is x0, x2, x3, x4 = FFFFFFFFFFFFFFFF and x1 = 0, for each of C = 1, 8 and 64 (done_o at 65, 9 and 2 cycles).
REQ-026 SHALL verify that a random state's result matches a bitwise reference model of S, and that a second start_i pulsed in RUN is ignored (one done_o only).
REQ-027 SHALL verify that reset_i asserted in RUN cycle 4 gives busy_o = 0, Ps_out_o = 0 and no done_o, and that a new start then completes normally.
REQ-028 SHALL verify that start_i held high through DONE launches back-to-back operations with done_o pulses 9 cycles apart (C=8).
REQ-029 SHALL verify, with PS_SERIAL_ABORT_EN defined, that abort_i in RUN cycle 3 returns the block to IDLE with chunks 0-2 substituted, chunks 3-7 equal to the input, and no done_o.
